// File: rtl/frag_reader_if.sv
// Bundle of the frag_reader control, FIFO read-port and output-stream signals.
interface frag_reader_if #(
  parameter int unsigned LEN_W = 12
);
  // control
  logic             start;
  logic [LEN_W-1:0] frag_len;
  logic             busy;
  logic             done;
  // reassembly FIFO read port
  logic [4:0]       fifo_index;
  logic [31:0]      fifo_dout;
  logic             fifo_rd_en;
  logic [3:0]       fifo_dout_index;
  // output beat stream
  logic [31:0]      m_data;
  logic [2:0]       m_bytes;
  logic             m_valid;
  logic             m_last;
  logic             m_ready;

  // design side
  modport slave (
    input  start, frag_len, fifo_index, fifo_dout, m_ready,
    output busy, done, fifo_rd_en, fifo_dout_index, m_data, m_bytes, m_valid, m_last
  );

  // environment side: control source, FIFO and downstream sink
  modport master (
    output start, frag_len, fifo_index, fifo_dout, m_ready,
    input  busy, done, fifo_rd_en, fifo_dout_index, m_data, m_bytes, m_valid, m_last
  );
endinterface

// File: rtl/frag_reader.sv
// Drains one fragment per start from the byte-granular reassembly FIFO and
// repacks the returned words into a valid/ready beat stream.
module frag_reader #(
  parameter int unsigned LEN_W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  frag_reader_if.slave bus
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned BYTES_W = 3;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned LVL_W   = 5;
  localparam int unsigned CNT_W   = 3;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [BYTES_W-1:0] bytes;
    logic               last;
  } beat_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [LEN_W-1:0]   r_rem;
  logic [LEN_W-1:0]   w_rem_nxt;
  logic               r_busy;
  logic               r_done;
  logic               w_done_nxt;

  // read issue stage (cycle the FIFO sees the request)
  logic               r_rd_en;
  logic [IDX_W-1:0]   r_rd_idx;
  logic               r_rd_last;
  // capture stage (cycle fifo_dout is valid)
  logic               r_cap_vld;
  logic [BYTES_W-1:0] r_cap_bytes;
  logic               r_cap_last;

  // 2-entry output buffer: head drives m_*, skid holds the second entry
  beat_t              r_head;
  logic               r_head_vld;
  beat_t              r_skid;
  logic               r_skid_vld;

  logic [LEN_W-1:0]   w_len_src;
  logic [BYTES_W-1:0] w_n;
  logic [LVL_W-1:0]   w_avail;
  logic               w_room;
  logic [CNT_W-1:0]   w_occ;
  logic [CNT_W-1:0]   w_infl;
  logic               w_pop;
  logic               w_push;
  logic               w_credit;
  logic               w_issue;
  logic               w_issue_last;
  logic [DATA_W-1:0]  w_mask;
  beat_t              w_new;

  // Read sizing, FIFO availability and output-buffer credit
  always_comb begin
    w_len_src = (r_state == IDLE) ? bus.frag_len : r_rem;
    w_n       = (w_len_src >= LEN_W'(4)) ? BYTES_W'(4) : BYTES_W'(w_len_src);
    // bytes of a request the FIFO is servicing this cycle are still counted in fifo_index
    w_avail   = bus.fifo_index - (r_rd_en ? LVL_W'(r_rd_idx) : LVL_W'(0));
    w_room    = (w_avail >= LVL_W'(w_n));
    w_pop     = r_head_vld && bus.m_ready;
    w_push    = r_cap_vld;
    w_occ     = CNT_W'(r_head_vld) + CNT_W'(r_skid_vld);
    // both pipeline stages hold a future buffer entry
    w_infl    = CNT_W'(r_rd_en) + CNT_W'(r_cap_vld);
    w_credit  = (w_occ + w_infl) < (CNT_W'(2) + CNT_W'(w_pop));
  end

  // Next-state, read issue and done decode
  always_comb begin
    w_state_nxt  = r_state;
    w_rem_nxt    = r_rem;
    w_issue      = 1'b0;
    w_issue_last = 1'b0;
    w_done_nxt   = 1'b0;
    unique case (r_state)
      IDLE, RUN: begin
        if ((r_state == RUN) || (bus.start && (bus.frag_len != '0))) begin
          w_state_nxt = RUN;
          w_rem_nxt   = w_len_src;
          if (w_room && w_credit) begin
            w_issue      = 1'b1;
            w_issue_last = (w_len_src == LEN_W'(w_n));
            w_rem_nxt    = w_len_src - LEN_W'(w_n);
            if (w_issue_last) begin
              w_state_nxt = FLUSH;
            end
          end
        end
      end
      FLUSH: begin
        if (w_pop && r_head.last) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, remaining length and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= w_done_nxt;
    end
  end

  // Read request and capture pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_en     <= 1'b0;
      r_rd_idx    <= '0;
      r_rd_last   <= 1'b0;
      r_cap_vld   <= 1'b0;
      r_cap_bytes <= '0;
      r_cap_last  <= 1'b0;
    end else begin
      r_rd_en     <= w_issue;
      r_rd_idx    <= w_issue ? IDX_W'(w_n) : IDX_W'(0);
      r_rd_last   <= w_issue && w_issue_last;
      r_cap_vld   <= r_rd_en;
      r_cap_bytes <= BYTES_W'(r_rd_idx);
      r_cap_last  <= r_rd_last;
    end
  end

  // Incoming beat with bytes beyond the requested count forced to zero
  always_comb begin
    unique case (r_cap_bytes)
      3'd1:    w_mask = 32'hFF00_0000;
      3'd2:    w_mask = 32'hFFFF_0000;
      3'd3:    w_mask = 32'hFFFF_FF00;
      default: w_mask = 32'hFFFF_FFFF;
    endcase
    w_new       = '0;
    w_new.data  = bus.fifo_dout & w_mask;
    w_new.bytes = r_cap_bytes;
    w_new.last  = r_cap_last;
  end

  // Output buffer: push from capture stage, pop on handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head     <= '0;
      r_head_vld <= 1'b0;
      r_skid     <= '0;
      r_skid_vld <= 1'b0;
    end else if (w_pop) begin
      if (r_skid_vld) begin
        r_head <= r_skid;
        if (w_push) begin
          r_skid <= w_new;
        end else begin
          r_skid     <= '0;
          r_skid_vld <= 1'b0;
        end
      end else if (w_push) begin
        r_head <= w_new;
      end else begin
        r_head     <= '0;
        r_head_vld <= 1'b0;
      end
    end else if (w_push) begin
      if (!r_head_vld) begin
        r_head     <= w_new;
        r_head_vld <= 1'b1;
      end else begin
        r_skid     <= w_new;
        r_skid_vld <= 1'b1;
      end
    end
  end

  assign bus.busy            = r_busy;
  assign bus.done            = r_done;
  assign bus.fifo_rd_en      = r_rd_en;
  assign bus.fifo_dout_index = r_rd_idx;
  assign bus.m_data          = r_head.data;
  assign bus.m_bytes         = r_head.bytes;
  assign bus.m_valid         = r_head_vld;
  assign bus.m_last          = r_head.last;

endmodule

// File: tb/tb_frag_reader.sv
// Bench for frag_reader: byte-queue FIFO model, beat scoreboard and directed cases.
module tb_frag_reader;

  localparam int unsigned LEN_W = 12;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  bytes;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  frag_reader_if #(.LEN_W(LEN_W)) bus ();

  frag_reader #(.LEN_W(LEN_W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  beat_t       sb[$];
  logic [7:0]  q_pend[$];
  logic [7:0]  fq[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          rd_cnt = 0;
  int          done_cnt = 0;
  int          beat_cnt = 0;
  int          clr_seq = 0;
  int          clr_seen = 0;
  int          pend_idx = 0;
  logic        stall_prev = 1'b0;
  logic [36:0] stall_snap = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fifo_add(input logic [7:0] first, input int cnt);
    for (int i = 0; i < cnt; i++) q_pend.push_back(8'(first + 8'(i)));
  endtask

  task automatic fifo_load(input logic [7:0] first, input int cnt);
    clr_seq++;
    fifo_add(first, cnt);
  endtask

  task automatic exp_beat(input logic [31:0] d, input logic [2:0] b, input logic l);
    sb.push_back({d, b, l});
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk(nm, 64'({bus.busy, bus.done, bus.fifo_rd_en, bus.fifo_dout_index,
                 bus.m_valid, bus.m_last, bus.m_bytes, bus.m_data}), 64'(0));
  endtask

  task automatic wait_done(input string nm, input int budget);
    bit seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({nm, "_done"}, 64'(seen), 64'(1));
    if (seen) chk({nm, "_busy_low_at_done"}, 64'(bus.busy), 64'(0));
  endtask

  task automatic pulse_start(input int len);
    bus.start    = 1'b1;
    bus.frag_len = LEN_W'(len);
    tick();
    bus.start    = 1'b0;
    bus.frag_len = '0;
  endtask

  // FIFO model: serve reads MSB-first, then apply clears and new bytes
  always @(posedge clk) begin
    logic [31:0] w;
    int          n;
    if (bus.fifo_rd_en) begin
      n = int'(bus.fifo_dout_index);
      chk("fifo_underflow", 64'(fq.size() >= n), 64'(1));
      w = '0;
      for (int b = 0; b < 4; b++) begin
        if ((b < n) && (fq.size() > 0)) w[31-8*b -: 8] = fq.pop_front();
        else                            w[31-8*b -: 8] = 8'hEE;
      end
      bus.fifo_dout <= w;
    end
    if (clr_seq != clr_seen) begin
      fq.delete();
      clr_seen = clr_seq;
    end
    while (pend_idx < q_pend.size()) begin
      fq.push_back(q_pend[pend_idx]);
      pend_idx++;
    end
    bus.fifo_index <= 5'(fq.size());
  end

  // Monitor: scoreboard on handshake, stall stability, event counters
  always @(negedge clk) begin
    beat_t e;
    if (rst_n) begin
      if (bus.fifo_rd_en) rd_cnt++;
      if (bus.done)       done_cnt++;
      if (stall_prev)
        chk("stall_hold", 64'({bus.m_valid, bus.m_data, bus.m_bytes, bus.m_last}), 64'(stall_snap));
      if (bus.m_valid && bus.m_ready) begin
        beat_cnt++;
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL beat_unexpected: got %0h/%0d/%0b expected none (t=%0t)",
                   bus.m_data, bus.m_bytes, bus.m_last, $time);
        end else begin
          e = sb.pop_front();
          chk("beat", 64'({bus.m_data, bus.m_bytes, bus.m_last}), 64'(e));
        end
      end
      stall_prev = bus.m_valid && !bus.m_ready;
      stall_snap = {bus.m_valid, bus.m_data, bus.m_bytes, bus.m_last};
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int d0;
    int b0;
    bit seen;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.frag_len = '0;
    bus.m_ready  = 1'b0;
    #12;
    chk_outputs_zero("reset_outputs");
    tick(2);
    rst_n = 1'b1;
    tick();

    // 8-byte clean run
    fifo_load(8'h11, 12);
    tick(2);
    chk("t1_fifo_index", 64'(bus.fifo_index), 64'(12));
    bus.m_ready = 1'b1;
    exp_beat(32'h1112_1314, 3'd4, 1'b0);
    exp_beat(32'h1516_1718, 3'd4, 1'b1);
    pulse_start(8);
    chk("t1_busy_c1", 64'(bus.busy), 64'(1));
    chk("t1_read_c1", 64'({bus.fifo_rd_en, bus.fifo_dout_index}), 64'({1'b1, 4'd4}));
    tick();
    chk("t1_read_c2", 64'({bus.fifo_rd_en, bus.fifo_dout_index}), 64'({1'b1, 4'd4}));
    tick();
    chk("t1_beat_c3", 64'({bus.m_valid, bus.m_last, bus.m_bytes, bus.fifo_rd_en}), 64'({1'b1, 1'b0, 3'd4, 1'b0}));
    tick();
    chk("t1_beat_c4", 64'({bus.m_valid, bus.m_last, bus.m_bytes}), 64'({1'b1, 1'b1, 3'd4}));
    tick();
    chk("t1_done_c5", 64'({bus.done, bus.busy, bus.m_valid}), 64'({1'b1, 1'b0, 1'b0}));
    tick();
    chk("t1_done_c6", 64'(bus.done), 64'(0));

    // partial final beat
    fifo_load(8'hA1, 6);
    tick(2);
    exp_beat(32'hA1A2_A3A4, 3'd4, 1'b0);
    exp_beat(32'hA5A6_0000, 3'd2, 1'b1);
    pulse_start(6);
    chk("t2_read1", 64'({bus.fifo_rd_en, bus.fifo_dout_index}), 64'({1'b1, 4'd4}));
    tick();
    chk("t2_read2", 64'({bus.fifo_rd_en, bus.fifo_dout_index}), 64'({1'b1, 4'd2}));
    wait_done("t2", 20);

    // starvation
    fifo_load(8'h31, 3);
    tick(2);
    exp_beat(32'h3132_3334, 3'd4, 1'b0);
    exp_beat(32'h3536_3738, 3'd4, 1'b1);
    pulse_start(8);
    chk("t3_busy", 64'(bus.busy), 64'(1));
    r0 = rd_cnt;
    tick(6);
    chk("t3_no_reads_at_3", 64'(rd_cnt - r0), 64'(0));
    fifo_add(8'h34, 1);
    tick();
    chk("t3_index_4", 64'({bus.fifo_index, bus.fifo_rd_en}), 64'({5'd4, 1'b0}));
    tick();
    chk("t3_read_at_4", 64'({bus.fifo_rd_en, bus.fifo_dout_index}), 64'({1'b1, 4'd4}));
    fifo_add(8'h35, 4);
    wait_done("t3", 30);

    // backpressure
    bus.m_ready = 1'b0;
    fifo_load(8'h41, 20);
    tick(2);
    exp_beat(32'h4142_4344, 3'd4, 1'b0);
    exp_beat(32'h4546_4748, 3'd4, 1'b0);
    exp_beat(32'h494A_4B4C, 3'd4, 1'b0);
    exp_beat(32'h4D4E_4F50, 3'd4, 1'b1);
    r0 = rd_cnt;
    pulse_start(16);
    tick(9);
    chk("t4_reads_stalled", 64'(rd_cnt - r0), 64'(2));
    chk("t4_stalled_head", 64'({bus.m_valid, bus.busy, bus.m_data}), 64'({1'b1, 1'b1, 32'h4142_4344}));
    bus.m_ready = 1'b1;
    wait_done("t4", 40);
    chk("t4_reads_total", 64'(rd_cnt - r0), 64'(4));
    chk("t4_fifo_left", 64'(fq.size()), 64'(4));

    // ignored starts
    r0 = rd_cnt;
    pulse_start(0);
    chk("t5_zero_len", 64'({bus.busy, bus.fifo_rd_en}), 64'(0));
    tick(3);
    chk("t5_zero_len_reads", 64'(rd_cnt - r0), 64'(0));
    fifo_load(8'h61, 8);
    tick(2);
    exp_beat(32'h6162_6364, 3'd4, 1'b0);
    exp_beat(32'h6566_6768, 3'd4, 1'b1);
    d0 = done_cnt;
    r0 = rd_cnt;
    pulse_start(8);
    pulse_start(4);
    wait_done("t5", 20);
    tick(5);
    chk("t5_one_done", 64'(done_cnt - d0), 64'(1));
    chk("t5_reads", 64'(rd_cnt - r0), 64'(2));
    chk("t5_idle", 64'(bus.busy), 64'(0));

    // reset mid-fragment
    fifo_load(8'h71, 12);
    tick(2);
    exp_beat(32'h7172_7374, 3'd4, 1'b0);
    b0 = beat_cnt;
    d0 = done_cnt;
    pulse_start(12);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (beat_cnt - b0 >= 1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t6_first_beat", 64'(seen), 64'(1));
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("t6_async_clear");
    tick(2);
    chk_outputs_zero("t6_held_clear");
    rst_n = 1'b1;
    tick();
    fifo_load(8'h81, 4);
    tick(2);
    exp_beat(32'h8182_8384, 3'd4, 1'b1);
    pulse_start(4);
    wait_done("t6", 20);
    tick(3);
    chk("t6_done_count", 64'(done_cnt - d0), 64'(1));
    chk("t6_beat_count", 64'(beat_cnt - b0), 64'(2));

    tick(3);
    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
